adma_dm_dst_sched: RTL and testbench
====================================

Name: adma_dm_dst_sched

Overview:
- Per-channel burst scheduler for the AXI-Stream destination datamover.
- Accepts one transfer descriptor per DMA channel: tdest and total beat count.
- Arbitrates round-robin among active channels and splits each transfer into bursts of at most MAX_BURST_LEN beats.
- Issues bursts on the datamover's atx_* info handshake, tracks per-channel completions from atx_done, and pulses chn_done when a channel's whole transfer has drained.

Parameters:
- DMA_CHN_NUM, 4, number of DMA channels.
- DST_TDEST_W, 2, AXIS tdest width.
- ATX_LEN_W, 8, burst length field width (beats-1 encoding).
- XFER_LEN_W, 16, descriptor length field width (beats-1 encoding).
- MAX_BURST_LEN, 256, maximum beats per burst; legal range 1..2^ATX_LEN_W.
- ATX_NUM_OSTD, DMA_CHN_NUM, maximum bursts issued but not yet done, summed over all channels.
- DMA_CHN_NUM_W, (DMA_CHN_NUM>1)?$clog2(DMA_CHN_NUM):1, derived; do not override.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous reset, active-high.
- req_vld  in  DMA_CHN_NUM  per-channel descriptor valid.
- req_rdy  out  DMA_CHN_NUM  per-channel descriptor ready; high only when that channel is IDLE.
- req_tdest  in  DMA_CHN_NUM*DST_TDEST_W  packed per-channel tdest.
- req_len  in  DMA_CHN_NUM*XFER_LEN_W  packed per-channel total beats minus 1.
- atx_chn_id  out  DMA_CHN_NUM_W  channel of the issued burst.
- atx_tdest  out  DST_TDEST_W  tdest of the issued burst.
- atx_tlen  out  ATX_LEN_W  burst beats minus 1.
- atx_vld  out  1  burst info valid.
- atx_rdy  in  1  burst info accepted by the datamover.
- atx_done  in  DMA_CHN_NUM  one-cycle pulse per completed burst, per channel.
- chn_busy  out  DMA_CHN_NUM  channel state is not IDLE.
- chn_done  out  DMA_CHN_NUM  one-cycle pulse when the channel's transfer completes.
- sched_err  out  1  sticky; set when atx_done arrives with no outstanding burst on that channel.

Behaviour:
- Reset: all outputs 0 except req_rdy = all ones; every channel IDLE; RR pointer = 0; all counters = 0.
- Per-channel FSM, IDLE -> ISSUE -> DRAIN -> IDLE:
  - IDLE: on req_vld&req_rdy, latch tdest, set rem = req_len+1 (XFER_LEN_W+1 bits), clear iss and cmp counters, go to ISSUE.
  - ISSUE: eligible for grant. When the burst that takes rem to 0 is accepted, go to DRAIN.
  - DRAIN: when cmp (including a done arriving this cycle) equals iss, pulse chn_done for one cycle and go to IDLE. req_rdy rises the following cycle.
- Output register (atx_chn_id, atx_tdest, atx_tlen, atx_vld):
  - Loads when (!atx_vld | atx_rdy) and a grant exists; otherwise atx_vld clears on atx_rdy.
  - Contents are held stable while atx_vld & !atx_rdy.
  - Back-to-back bursts are allowed, one per cycle.
- Grant:
  - Round-robin among channels in ISSUE, starting at the RR pointer.
  - Suppressed when ostd + atx_vld >= ATX_NUM_OSTD. A burst in the output register counts as reserved.
  - On load, the RR pointer moves to granted+1 mod DMA_CHN_NUM.
- Burst size: burst = min(rem, MAX_BURST_LEN), atx_tlen = burst-1, rem -= burst at load time.
- Latency: descriptor accepted in cycle t -> atx_vld is high at the earliest in cycle t+2.
- Counters:
  - Per channel, iss increments on atx_vld&atx_rdy for that channel; cmp increments on atx_done.
  - Global ostd = +1 on the atx handshake, -popcount(atx_done). Simultaneous increment and decrement are both applied in the same cycle.
- atx_done on a channel whose cmp == iss: set sched_err and ignore the pulse. sched_err clears only on reset.
- Descriptor acceptance, arbitration and completion on different channels in the same cycle must all take effect.
- Reset mid-transfer: state is dropped and no chn_done is emitted; sched_err clears.
- Width checks: the iss and cmp counters are XFER_LEN_W+1 bits wide and must not wrap.

Decomposition:
- Package adma_sched_pkg holds:
  - chn_state_e enum: IDLE, ISSUE, DRAIN.
  - Helper function min_len.
- One sub-module, adma_rr_arb:
  - Parameterized DMA_CHN_NUM round-robin arbiter.
  - Inputs: request vector, pointer. Outputs: one-hot grant, encoded index, any.
  - Purely combinational; the pointer register stays in the parent.

Test Plan:
- ch0 req_len=599, MAX_BURST_LEN=256, atx_rdy=1 -> atx_tlen sequence 255, 255, 87 on chn 0; chn_done[0] pulses one cycle after the third atx_done[0].
- ch0..3 each req_len=511, simultaneous -> grants interleave 0, 1, 2, 3, 0, 1, 2, 3; each channel's chn_done fires after its 2nd done.
- ATX_NUM_OSTD=2, no atx_done returned -> exactly 2 handshakes, then atx_vld stays 0; one atx_done pulse -> next burst issued.
- atx_rdy held low 5 cycles while atx_vld=1 -> outputs stable, RR pointer and rem unchanged.
- atx_done[2] with ch2 IDLE -> sched_err=1 and stays 1; areset -> sched_err=0, req_rdy=all ones.
- areset asserted while ch1 is in DRAIN -> next cycle chn_busy=0, atx_vld=0, no chn_done.

Source files
------------

// File: rtl/adma_sched_pkg.sv
// adma_sched_pkg: shared channel state type and burst sizing helper for the destination scheduler.
package adma_sched_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} chn_state_e;

    function automatic logic [31:0] min_len(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/adma_rr_arb.sv
// adma_rr_arb: combinational round-robin arbiter, first requester at or after ptr wins.
module adma_rr_arb #(
    parameter int DMA_CHN_NUM   = 4,
    parameter int DMA_CHN_NUM_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
) (
    input  logic [DMA_CHN_NUM-1:0]   req,
    input  logic [DMA_CHN_NUM_W-1:0] ptr,
    output logic [DMA_CHN_NUM-1:0]   gnt,
    output logic [DMA_CHN_NUM_W-1:0] idx,
    output logic                     any
);

    always_comb begin
        int c;
        c   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // walk offsets from farthest to nearest so the nearest requester is kept
        for (int i = DMA_CHN_NUM - 1; i >= 0; i--) begin
            c = (int'(ptr) + i) % DMA_CHN_NUM;
            if (req[c]) begin
                gnt    = '0;
                gnt[c] = 1'b1;
                idx    = DMA_CHN_NUM_W'(c);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adma_dm_dst_sched.sv
// adma_dm_dst_sched: per-channel burst scheduler feeding the AXIS destination datamover,
// splitting descriptors into bursts, arbitrating round-robin and tracking completions.
module adma_dm_dst_sched
    import adma_sched_pkg::*;
#(
    parameter int DMA_CHN_NUM   = 4,
    parameter int DST_TDEST_W   = 2,
    parameter int ATX_LEN_W     = 8,
    parameter int XFER_LEN_W    = 16,
    parameter int MAX_BURST_LEN = 256,
    parameter int ATX_NUM_OSTD  = DMA_CHN_NUM,
    parameter int DMA_CHN_NUM_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [DMA_CHN_NUM-1:0]            req_vld,
    output logic [DMA_CHN_NUM-1:0]            req_rdy,
    input  logic [DMA_CHN_NUM*DST_TDEST_W-1:0] req_tdest,
    input  logic [DMA_CHN_NUM*XFER_LEN_W-1:0]  req_len,
    output logic [DMA_CHN_NUM_W-1:0]          atx_chn_id,
    output logic [DST_TDEST_W-1:0]            atx_tdest,
    output logic [ATX_LEN_W-1:0]              atx_tlen,
    output logic                              atx_vld,
    input  logic                              atx_rdy,
    input  logic [DMA_CHN_NUM-1:0]            atx_done,
    output logic [DMA_CHN_NUM-1:0]            chn_busy,
    output logic [DMA_CHN_NUM-1:0]            chn_done,
    output logic                              sched_err
);

    localparam int CNT_W  = XFER_LEN_W + 1;
    localparam int OSTD_W = $clog2(ATX_NUM_OSTD + 1);

    chn_state_e               st      [DMA_CHN_NUM];
    chn_state_e               st_nxt  [DMA_CHN_NUM];
    logic [DST_TDEST_W-1:0]   tdest_q [DMA_CHN_NUM];
    logic [CNT_W-1:0]         rem     [DMA_CHN_NUM];
    logic [CNT_W-1:0]         iss     [DMA_CHN_NUM];
    logic [CNT_W-1:0]         cmp     [DMA_CHN_NUM];
    logic [OSTD_W-1:0]        ostd;
    logic [DMA_CHN_NUM_W-1:0] rr_ptr;
    logic [DMA_CHN_NUM_W-1:0] gnt_idx;
    logic [DMA_CHN_NUM-1:0]   issue_req;
    logic [DMA_CHN_NUM-1:0]   gnt;
    logic [DMA_CHN_NUM-1:0]   done_ok;
    logic [DMA_CHN_NUM-1:0]   hs_chn;
    logic                     gnt_any;
    logic                     hs;
    logic                     ld;
    logic [31:0]              burst;

    adma_rr_arb #(
        .DMA_CHN_NUM  (DMA_CHN_NUM),
        .DMA_CHN_NUM_W(DMA_CHN_NUM_W)
    ) u_arb (
        .req(issue_req),
        .ptr(rr_ptr),
        .gnt(gnt),
        .idx(gnt_idx),
        .any(gnt_any)
    );

    always_comb begin
        issue_req = '0;
        done_ok   = '0;
        hs_chn    = '0;
        req_rdy   = '0;
        chn_busy  = '0;
        hs        = atx_vld && atx_rdy;
        for (int c = 0; c < DMA_CHN_NUM; c++) begin
            issue_req[c] = (st[c] == ISSUE) && (rem[c] != '0);
            done_ok[c]   = atx_done[c] && (cmp[c] != iss[c]);
            hs_chn[c]    = hs && (atx_chn_id == DMA_CHN_NUM_W'(c));
            req_rdy[c]   = st[c] == IDLE;
            chn_busy[c]  = st[c] != IDLE;
        end
    end

    // a burst parked in the output register already holds an outstanding slot
    assign ld = (!atx_vld || atx_rdy) && gnt_any &&
                ((OSTD_W+1)'(ostd) + (OSTD_W+1)'(atx_vld) < (OSTD_W+1)'(ATX_NUM_OSTD));
    assign burst = min_len(32'(rem[gnt_idx]), 32'(MAX_BURST_LEN));

    always_comb begin
        st_nxt = st;
        for (int c = 0; c < DMA_CHN_NUM; c++) begin
            case (st[c])
                IDLE:    if (req_vld[c]) st_nxt[c] = ISSUE;
                ISSUE:   if (hs_chn[c] && rem[c] == '0) st_nxt[c] = DRAIN;
                DRAIN:   if (cmp[c] + CNT_W'(done_ok[c]) == iss[c]) st_nxt[c] = IDLE;
                default: st_nxt[c] = IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int c = 0; c < DMA_CHN_NUM; c++) begin
                st[c]      <= IDLE;
                tdest_q[c] <= '0;
                rem[c]     <= '0;
                iss[c]     <= '0;
                cmp[c]     <= '0;
            end
            ostd       <= '0;
            rr_ptr     <= '0;
            atx_vld    <= 1'b0;
            atx_chn_id <= '0;
            atx_tdest  <= '0;
            atx_tlen   <= '0;
            chn_done   <= '0;
            sched_err  <= 1'b0;
        end else begin
            if (ld) begin
                atx_vld    <= 1'b1;
                atx_chn_id <= gnt_idx;
                atx_tdest  <= tdest_q[gnt_idx];
                atx_tlen   <= ATX_LEN_W'(burst - 32'd1);
                rr_ptr     <= (gnt_idx == DMA_CHN_NUM_W'(DMA_CHN_NUM - 1)) ? '0 : gnt_idx + DMA_CHN_NUM_W'(1);
            end else if (atx_rdy) begin
                atx_vld <= 1'b0;
            end
            ostd <= ostd + OSTD_W'(hs) - OSTD_W'($countones(done_ok));
            if ((atx_done & ~done_ok) != '0) sched_err <= 1'b1;
            for (int c = 0; c < DMA_CHN_NUM; c++) begin
                st[c]       <= st_nxt[c];
                chn_done[c] <= (st[c] == DRAIN) && (st_nxt[c] == IDLE);
                if (st[c] == IDLE && req_vld[c]) begin
                    tdest_q[c] <= req_tdest[c*DST_TDEST_W +: DST_TDEST_W];
                    rem[c]     <= CNT_W'(req_len[c*XFER_LEN_W +: XFER_LEN_W]) + CNT_W'(1);
                    iss[c]     <= '0;
                    cmp[c]     <= '0;
                end else begin
                    if (ld && gnt[c]) rem[c] <= rem[c] - CNT_W'(burst);
                    if (hs_chn[c]) iss[c] <= iss[c] + CNT_W'(1);
                    if (done_ok[c]) cmp[c] <= cmp[c] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_adma_dm_dst_sched.sv
// tb_adma_dm_dst_sched: directed bench for the destination burst scheduler,
// one instance at default outstanding depth and one limited to two outstanding bursts.
module tb_adma_dm_dst_sched;

    logic        aclk = 1'b0;
    logic        areset;
    logic [3:0]  req_vld;
    logic [7:0]  req_tdest;
    logic [63:0] req_len;
    logic        atx_rdy;
    logic [3:0]  atx_done;

    logic [3:0]  a_req_rdy, a_chn_busy, a_chn_done;
    logic [1:0]  a_atx_chn_id, a_atx_tdest;
    logic [7:0]  a_atx_tlen;
    logic        a_atx_vld, a_sched_err;

    logic [3:0]  b_req_rdy, b_chn_busy, b_chn_done;
    logic [1:0]  b_atx_chn_id, b_atx_tdest;
    logic [7:0]  b_atx_tlen;
    logic        b_atx_vld, b_sched_err;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    adma_dm_dst_sched dut_a (
        .aclk(aclk), .areset(areset),
        .req_vld(req_vld), .req_rdy(a_req_rdy), .req_tdest(req_tdest), .req_len(req_len),
        .atx_chn_id(a_atx_chn_id), .atx_tdest(a_atx_tdest), .atx_tlen(a_atx_tlen),
        .atx_vld(a_atx_vld), .atx_rdy(atx_rdy), .atx_done(atx_done),
        .chn_busy(a_chn_busy), .chn_done(a_chn_done), .sched_err(a_sched_err)
    );

    adma_dm_dst_sched #(.ATX_NUM_OSTD(2)) dut_b (
        .aclk(aclk), .areset(areset),
        .req_vld(req_vld), .req_rdy(b_req_rdy), .req_tdest(req_tdest), .req_len(req_len),
        .atx_chn_id(b_atx_chn_id), .atx_tdest(b_atx_tdest), .atx_tlen(b_atx_tlen),
        .atx_vld(b_atx_vld), .atx_rdy(atx_rdy), .atx_done(atx_done),
        .chn_busy(b_chn_busy), .chn_done(b_chn_done), .sched_err(b_sched_err)
    );

    task automatic step;
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset;
        areset   = 1'b1;
        req_vld  = '0;
        atx_done = '0;
        atx_rdy  = 1'b0;
        step;
        step;
        areset = 1'b0;
    endtask

    task automatic set_req(input int c, input logic [1:0] td, input logic [15:0] len);
        req_tdest[c*2 +: 2]   = td;
        req_len[c*16 +: 16]   = len;
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (a_req_rdy !== 4'hF) begin errors++; $display("FAIL reset_req_rdy: got %h exp F", a_req_rdy); end
        checks++; if (a_atx_vld !== 1'b0) begin errors++; $display("FAIL reset_atx_vld: got %b exp 0", a_atx_vld); end
        checks++; if (a_chn_busy !== 4'h0) begin errors++; $display("FAIL reset_chn_busy: got %h exp 0", a_chn_busy); end
        checks++; if (a_chn_done !== 4'h0) begin errors++; $display("FAIL reset_chn_done: got %h exp 0", a_chn_done); end
        checks++; if (a_sched_err !== 1'b0) begin errors++; $display("FAIL reset_sched_err: got %b exp 0", a_sched_err); end
        checks++; if ({a_atx_chn_id, a_atx_tdest, a_atx_tlen} !== 12'h0) begin errors++; $display("FAIL reset_atx_fields: got %h exp 0", {a_atx_chn_id, a_atx_tdest, a_atx_tlen}); end
        checks++; if (b_req_rdy !== 4'hF) begin errors++; $display("FAIL reset_b_req_rdy: got %h exp F", b_req_rdy); end
    endtask

    task automatic test_split;
        int n;
        int bad_chn;
        logic [7:0] tl [3];
        n = 0;
        bad_chn = 0;
        do_reset;
        set_req(0, 2'd1, 16'd599);
        atx_rdy = 1'b1;
        req_vld = 4'b0001;
        step;
        req_vld = '0;
        checks++; if ({a_chn_busy, a_req_rdy} !== 8'h1E) begin errors++; $display("FAIL split_accept: got %h exp 1E", {a_chn_busy, a_req_rdy}); end
        checks++; if (a_atx_vld !== 1'b0) begin errors++; $display("FAIL split_latency_t1: got %b exp 0", a_atx_vld); end
        step;
        checks++; if (a_atx_vld !== 1'b1) begin errors++; $display("FAIL split_latency_t2: got %b exp 1", a_atx_vld); end
        for (int i = 0; i < 10; i++) begin
            if (a_atx_vld && atx_rdy) begin
                if (n < 3) tl[n] = a_atx_tlen;
                if (a_atx_chn_id !== 2'd0 || a_atx_tdest !== 2'd1) bad_chn++;
                n++;
            end
            step;
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL split_count: got %0d exp 3", n); end
        checks++; if (bad_chn !== 0) begin errors++; $display("FAIL split_chn_tdest: got %0d bad exp 0", bad_chn); end
        if (n == 3) begin
            checks++; if ({tl[0], tl[1], tl[2]} !== {8'd255, 8'd255, 8'd87}) begin errors++; $display("FAIL split_tlen: got %0d %0d %0d exp 255 255 87", tl[0], tl[1], tl[2]); end
        end
        checks++; if ({a_atx_vld, a_chn_busy} !== 5'b0_0001) begin errors++; $display("FAIL split_drain: got %b exp 00001", {a_atx_vld, a_chn_busy}); end
        for (int k = 0; k < 3; k++) begin
            atx_done = 4'b0001;
            step;
            atx_done = '0;
            checks++; if (a_chn_done !== ((k == 2) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL split_chn_done_%0d: got %h", k, a_chn_done); end
        end
        checks++; if (a_req_rdy !== 4'hF) begin errors++; $display("FAIL split_rdy_back: got %h exp F", a_req_rdy); end
        step;
        checks++; if (a_chn_done !== 4'h0) begin errors++; $display("FAIL split_done_pulse: got %h exp 0", a_chn_done); end
        checks++; if (a_sched_err !== 1'b0) begin errors++; $display("FAIL split_err: got %b exp 0", a_sched_err); end
    endtask

    task automatic test_back_to_back;
        int n, first, last;
        int gch [8];
        int gtd [8];
        int gl  [8];
        int done_cnt [4];
        int cdone [4];
        logic [3:0] pend;
        n = 0;
        first = -1;
        last = -1;
        pend = '0;
        for (int c = 0; c < 4; c++) begin
            done_cnt[c] = 0;
            cdone[c] = 0;
        end
        do_reset;
        for (int c = 0; c < 4; c++) set_req(c, 2'(c), 16'd511);
        atx_rdy = 1'b1;
        req_vld = 4'hF;
        step;
        req_vld = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            step;
            atx_done = pend;
            pend = '0;
            for (int c = 0; c < 4; c++) begin
                if (a_chn_done[c]) begin
                    cdone[c]++;
                    checks++; if (done_cnt[c] !== 2) begin errors++; $display("FAIL b2b_done_after_ch%0d: got %0d dones exp 2", c, done_cnt[c]); end
                end
                if (atx_done[c]) done_cnt[c]++;
            end
            if (a_atx_vld && atx_rdy) begin
                if (n < 8) begin
                    gch[n] = int'(a_atx_chn_id);
                    gtd[n] = int'(a_atx_tdest);
                    gl[n]  = int'(a_atx_tlen);
                end
                if (first < 0) first = cyc;
                last = cyc;
                n++;
                pend[a_atx_chn_id] = 1'b1;
            end
        end
        atx_done = '0;
        checks++; if (n !== 8) begin errors++; $display("FAIL b2b_count: got %0d exp 8", n); end
        if (n == 8) begin
            for (int i = 0; i < 8; i++) begin
                checks++; if (gch[i] !== i % 4 || gtd[i] !== i % 4 || gl[i] !== 255) begin errors++; $display("FAIL b2b_grant_%0d: got chn %0d tdest %0d tlen %0d exp chn %0d tdest %0d tlen 255", i, gch[i], gtd[i], gl[i], i % 4, i % 4); end
            end
        end
        checks++; if (last - first !== 7) begin errors++; $display("FAIL b2b_one_per_cycle: got span %0d exp 7", last - first); end
        for (int c = 0; c < 4; c++) begin
            checks++; if (cdone[c] !== 1) begin errors++; $display("FAIL b2b_chn_done_ch%0d: got %0d pulses exp 1", c, cdone[c]); end
        end
        checks++; if (a_chn_busy !== 4'h0) begin errors++; $display("FAIL b2b_idle: got %h exp 0", a_chn_busy); end
    endtask

    task automatic test_ostd_limit;
        int n;
        n = 0;
        do_reset;
        set_req(0, 2'd0, 16'd2047);
        atx_rdy = 1'b1;
        req_vld = 4'b0001;
        step;
        req_vld = '0;
        for (int i = 0; i < 10; i++) begin
            step;
            if (b_atx_vld && atx_rdy) n++;
        end
        checks++; if (n !== 2) begin errors++; $display("FAIL ostd_count: got %0d exp 2", n); end
        checks++; if (b_atx_vld !== 1'b0) begin errors++; $display("FAIL ostd_stall: got %b exp 0", b_atx_vld); end
        atx_done = 4'b0001;
        step;
        atx_done = '0;
        checks++; if (b_atx_vld !== 1'b0) begin errors++; $display("FAIL ostd_release_t0: got %b exp 0", b_atx_vld); end
        step;
        checks++; if ({b_atx_vld, b_atx_tlen} !== {1'b1, 8'd255}) begin errors++; $display("FAIL ostd_release_t1: got %h exp 1FF", {b_atx_vld, b_atx_tlen}); end
        step;
        checks++; if (b_atx_vld !== 1'b0) begin errors++; $display("FAIL ostd_relimit: got %b exp 0", b_atx_vld); end
        checks++; if (b_sched_err !== 1'b0) begin errors++; $display("FAIL ostd_err: got %b exp 0", b_sched_err); end
    endtask

    task automatic test_stall;
        int n;
        logic [11:0] hsv [4];
        logic [11:0] exp_hs [4];
        n = 0;
        exp_hs[0] = {2'd0, 2'd2, 8'd255};
        exp_hs[1] = {2'd1, 2'd1, 8'd255};
        exp_hs[2] = {2'd0, 2'd2, 8'd255};
        exp_hs[3] = {2'd0, 2'd2, 8'd87};
        do_reset;
        set_req(0, 2'd2, 16'd599);
        set_req(1, 2'd1, 16'd255);
        req_vld = 4'b0011;
        step;
        req_vld = '0;
        step;
        for (int i = 0; i < 6; i++) begin
            checks++; if ({a_atx_vld, a_atx_chn_id, a_atx_tdest, a_atx_tlen} !== {1'b1, 2'd0, 2'd2, 8'd255}) begin errors++; $display("FAIL stall_hold_%0d: got %h exp 12FF", i, {a_atx_vld, a_atx_chn_id, a_atx_tdest, a_atx_tlen}); end
            if (i < 5) step;
        end
        checks++; if (dut_a.rr_ptr !== 2'd1) begin errors++; $display("FAIL stall_rr_ptr: got %0d exp 1", dut_a.rr_ptr); end
        checks++; if (dut_a.rem[0] !== 17'd344 || dut_a.rem[1] !== 17'd256) begin errors++; $display("FAIL stall_rem: got %0d %0d exp 344 256", dut_a.rem[0], dut_a.rem[1]); end
        atx_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (a_atx_vld && atx_rdy) begin
                if (n < 4) hsv[n] = {a_atx_chn_id, a_atx_tdest, a_atx_tlen};
                n++;
            end
            step;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL stall_count: got %0d exp 4", n); end
        if (n == 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (hsv[i] !== exp_hs[i]) begin errors++; $display("FAIL stall_seq_%0d: got %h exp %h", i, hsv[i], exp_hs[i]); end
            end
        end
    endtask

    task automatic test_sched_err;
        do_reset;
        atx_done = 4'b0100;
        step;
        atx_done = '0;
        checks++; if (a_sched_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b exp 1", a_sched_err); end
        checks++; if ({a_req_rdy, a_chn_done} !== 8'hF0) begin errors++; $display("FAIL err_no_side_effect: got %h exp F0", {a_req_rdy, a_chn_done}); end
        step;
        step;
        step;
        checks++; if (a_sched_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b exp 1", a_sched_err); end
        areset = 1'b1;
        step;
        areset = 1'b0;
        checks++; if ({a_sched_err, a_req_rdy} !== 5'h0F) begin errors++; $display("FAIL err_cleared: got %h exp 0F", {a_sched_err, a_req_rdy}); end
    endtask

    task automatic test_reset_drain;
        do_reset;
        set_req(1, 2'd3, 16'd9);
        atx_rdy = 1'b1;
        req_vld = 4'b0010;
        step;
        req_vld = '0;
        step;
        checks++; if ({a_atx_vld, a_atx_chn_id, a_atx_tdest, a_atx_tlen} !== {1'b1, 2'd1, 2'd3, 8'd9}) begin errors++; $display("FAIL rstdrain_burst: got %h exp 1709", {a_atx_vld, a_atx_chn_id, a_atx_tdest, a_atx_tlen}); end
        step;
        step;
        checks++; if ({a_chn_busy, a_atx_vld, a_chn_done} !== 9'b0010_0_0000) begin errors++; $display("FAIL rstdrain_in_drain: got %b exp 001000000", {a_chn_busy, a_atx_vld, a_chn_done}); end
        areset = 1'b1;
        step;
        checks++; if ({a_chn_busy, a_atx_vld, a_chn_done, a_req_rdy} !== 13'b0000_0_0000_1111) begin errors++; $display("FAIL rstdrain_cleared: got %b", {a_chn_busy, a_atx_vld, a_chn_done, a_req_rdy}); end
        areset = 1'b0;
        step;
        checks++; if (a_chn_done !== 4'h0) begin errors++; $display("FAIL rstdrain_no_done: got %h exp 0", a_chn_done); end
        atx_done = 4'b0010;
        step;
        atx_done = '0;
        checks++; if ({a_sched_err, a_chn_done} !== 5'b1_0000) begin errors++; $display("FAIL rstdrain_stale_done: got %b exp 10000", {a_sched_err, a_chn_done}); end
    endtask

    initial begin
        areset    = 1'b1;
        req_vld   = '0;
        req_tdest = '0;
        req_len   = '0;
        atx_rdy   = 1'b0;
        atx_done  = '0;
        test_reset;
        test_split;
        test_back_to_back;
        test_ostd_limit;
        test_stall;
        test_sched_err;
        test_reset_drain;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
